// File: rtl/mac_kbd_pkg.sv
// Shared constants, FSM state type and transition-byte helper for the Mac M0110 keyboard bridge.
package mac_kbd_pkg;

    localparam logic [7:0] CMD_INQUIRY = 8'h10;
    localparam logic [7:0] CMD_INSTANT = 8'h14;
    localparam logic [7:0] CMD_MODEL   = 8'h16;
    localparam logic [7:0] CMD_TEST    = 8'h36;

    localparam logic [7:0] RSP_NULL    = 8'h7B;
    localparam logic [7:0] RSP_MODEL   = 8'h0B;
    localparam logic [7:0] RSP_ACK     = 8'h7D;
    localparam logic [7:0] RSP_UNKNOWN = 8'h77;

    localparam logic [6:0] RAW_UNMAPPED = 7'h7F;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_KEY = 2'd1,
        RESPOND  = 2'd2
    } state_e;

    // Mac transition byte: bit 7 set on key release, raw code in [6:1], bit 0 always set.
    function automatic logic [7:0] transition_byte(input logic pressed, input logic [6:0] raw);
        return {~pressed, raw[5:0], 1'b1};
    endfunction

endpackage

// File: rtl/mac_kbd_bridge_lut.sv
// ps2_mac_lut: combinational map from {extended, PS/2 set-2 scancode} to a 7-bit Mac M0110 raw key code.
module ps2_mac_lut
    import mac_kbd_pkg::*;
(
    input  logic [8:0] idx_i,
    output logic [6:0] raw_o
);

    // Anything not listed has no M0110 equivalent and is reported as unmapped.
    always_comb begin
        raw_o = RAW_UNMAPPED;
        case (idx_i)
            9'h01C: raw_o = 7'h00;  // A
            9'h01B: raw_o = 7'h01;  // S
            9'h023: raw_o = 7'h02;  // D
            9'h02B: raw_o = 7'h03;  // F
            9'h033: raw_o = 7'h04;  // H
            9'h034: raw_o = 7'h05;  // G
            9'h01A: raw_o = 7'h06;
            9'h022: raw_o = 7'h07;
            9'h021: raw_o = 7'h08;
            9'h02A: raw_o = 7'h09;
            9'h032: raw_o = 7'h0B;
            9'h015: raw_o = 7'h0C;
            9'h01D: raw_o = 7'h0D;
            9'h024: raw_o = 7'h0E;
            9'h02D: raw_o = 7'h0F;
            9'h035: raw_o = 7'h10;
            9'h02C: raw_o = 7'h11;
            9'h016: raw_o = 7'h12;
            9'h01E: raw_o = 7'h13;
            9'h026: raw_o = 7'h14;
            9'h025: raw_o = 7'h15;
            9'h036: raw_o = 7'h16;
            9'h02E: raw_o = 7'h17;
            9'h055: raw_o = 7'h18;
            9'h046: raw_o = 7'h19;
            9'h03D: raw_o = 7'h1A;
            9'h04E: raw_o = 7'h1B;
            9'h03E: raw_o = 7'h1C;
            9'h045: raw_o = 7'h1D;
            9'h05B: raw_o = 7'h1E;
            9'h044: raw_o = 7'h1F;
            9'h03C: raw_o = 7'h20;
            9'h054: raw_o = 7'h21;
            9'h043: raw_o = 7'h22;
            9'h04D: raw_o = 7'h23;
            9'h05A: raw_o = 7'h24;  // Return
            9'h04B: raw_o = 7'h25;
            9'h03B: raw_o = 7'h26;
            9'h052: raw_o = 7'h27;
            9'h042: raw_o = 7'h28;
            9'h04C: raw_o = 7'h29;
            9'h05D: raw_o = 7'h2A;
            9'h041: raw_o = 7'h2B;
            9'h04A: raw_o = 7'h2C;
            9'h031: raw_o = 7'h2D;
            9'h03A: raw_o = 7'h2E;
            9'h049: raw_o = 7'h2F;
            9'h00D: raw_o = 7'h30;
            9'h029: raw_o = 7'h31;
            9'h00E: raw_o = 7'h32;
            9'h066: raw_o = 7'h33;
            9'h15A: raw_o = 7'h34;  // keypad Enter maps to Mac Enter
            9'h014: raw_o = 7'h37;  // left Ctrl acts as Command
            9'h11F: raw_o = 7'h37;
            9'h012: raw_o = 7'h38;
            9'h059: raw_o = 7'h38;
            9'h058: raw_o = 7'h39;
            9'h011: raw_o = 7'h3A;  // Alt acts as Option
            9'h111: raw_o = 7'h3A;
            default: raw_o = RAW_UNMAPPED;
        endcase
    end

endmodule

// File: rtl/mac_kbd_bridge.sv
// mac_kbd_bridge: queues PS/2 key events as M0110 transition bytes and answers Mac keyboard commands.
module mac_kbd_bridge
    import mac_kbd_pkg::*;
#(
    parameter int c_mhz        = 27000000,
    parameter int c_fifo_depth = 8,
    parameter int c_inquiry_ms = 250
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] ps2_key,
    input  logic        cmd_valid,
    input  logic [7:0]  cmd_byte,
    output logic        cmd_ready,
    output logic        rsp_valid,
    output logic [7:0]  rsp_byte,
    input  logic        rsp_ready,
    output logic        overflow
);

    localparam int     AW         = $clog2(c_fifo_depth);
    localparam longint TIMEOUT_L  = (longint'(c_inquiry_ms) * longint'(c_mhz)) / 64'sd1000 - 64'sd1;
    localparam int     TW         = (TIMEOUT_L > 64'sd1) ? $clog2(TIMEOUT_L + 64'sd1) : 1;
    localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMEOUT_L);

    logic             toggle_q, toggle_d;
    logic             primed_q, primed_d;
    logic [6:0]       raw_s;
    logic             push_s, push_ok_s, pop_s, empty_s, full_s;
    logic [7:0]       push_byte_s, head_s;
    logic [7:0]       fifo_mem_q [c_fifo_depth];
    logic [7:0]       fifo_mem_d [c_fifo_depth];
    logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic             overflow_q, overflow_d;

    state_e           state_q, state_d;
    logic             cmd_pend_q, cmd_pend_d;
    logic [7:0]       cmd_q, cmd_d;
    logic             cmd_ready_q, cmd_ready_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [7:0]       rsp_byte_q, rsp_byte_d;
    logic [TW-1:0]    timer_q, timer_d;

    ps2_mac_lut u_lut (
        .idx_i ({ps2_key[8], ps2_key[7:0]}),
        .raw_o (raw_s)
    );

    // The first cycle after reset only captures the toggle bit, so a toggle level held through reset is not an event.
    always_comb begin
        toggle_d    = ps2_key[10];
        primed_d    = 1'b1;
        push_s      = primed_q && (ps2_key[10] != toggle_q) && (raw_s != RAW_UNMAPPED);
        push_byte_s = transition_byte(ps2_key[9], raw_s);
    end

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    always_comb begin
        empty_s   = (wr_ptr_q == rd_ptr_q);
        full_s    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        head_s    = fifo_mem_q[rd_ptr_q[AW-1:0]];
        push_ok_s = push_s && !full_s;
    end

    // FIFO next state; a push arriving while full is dropped and latched into the sticky overflow flag.
    always_comb begin
        fifo_mem_d = fifo_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q | (push_s && full_s);
        if (push_ok_s) begin
            fifo_mem_d[wr_ptr_q[AW-1:0]] = push_byte_s;
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // Command FSM next state: an accepted byte is latched first and decoded on the following cycle.
    always_comb begin
        state_d     = state_q;
        cmd_pend_d  = cmd_pend_q;
        cmd_d       = cmd_q;
        rsp_valid_d = rsp_valid_q;
        rsp_byte_d  = rsp_byte_q;
        timer_d     = timer_q;
        pop_s       = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_pend_q) begin
                    cmd_pend_d  = 1'b0;
                    state_d     = RESPOND;
                    rsp_valid_d = 1'b1;
                    case (cmd_q)
                        CMD_INQUIRY: begin
                            if (!empty_s) begin
                                pop_s      = 1'b1;
                                rsp_byte_d = head_s;
                            end else begin
                                state_d     = WAIT_KEY;
                                rsp_valid_d = 1'b0;
                                timer_d     = TIMER_LOAD;
                            end
                        end
                        CMD_INSTANT: begin
                            if (!empty_s) begin
                                pop_s      = 1'b1;
                                rsp_byte_d = head_s;
                            end else begin
                                rsp_byte_d = RSP_NULL;
                            end
                        end
                        CMD_MODEL: rsp_byte_d = RSP_MODEL;
                        CMD_TEST:  rsp_byte_d = RSP_ACK;
                        default:   rsp_byte_d = RSP_UNKNOWN;
                    endcase
                end else if (cmd_valid && cmd_ready_q) begin
                    cmd_pend_d = 1'b1;
                    cmd_d      = cmd_byte;
                end else begin
                    cmd_pend_d = 1'b0;
                end
            end
            WAIT_KEY: begin
                if (!empty_s) begin
                    pop_s       = 1'b1;
                    rsp_byte_d  = head_s;
                    rsp_valid_d = 1'b1;
                    state_d     = RESPOND;
                end else if (push_s) begin
                    // A key landing on the final timer cycle is served next cycle instead of the null reply.
                    timer_d = timer_q;
                end else if (timer_q == TW'(0)) begin
                    rsp_byte_d  = RSP_NULL;
                    rsp_valid_d = 1'b1;
                    state_d     = RESPOND;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            RESPOND: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    rsp_valid_d = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                rsp_valid_d = 1'b0;
                cmd_pend_d  = 1'b0;
            end
        endcase
        cmd_ready_d = (state_d == IDLE) && !cmd_pend_d;
    end

    // Event-detect and FIFO storage registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            toggle_q   <= 1'b0;
            primed_q   <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < c_fifo_depth; i++) begin
                fifo_mem_q[i] <= 8'h00;
            end
        end else begin
            toggle_q   <= toggle_d;
            primed_q   <= primed_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
            fifo_mem_q <= fifo_mem_d;
        end
    end

    // Command FSM registers, including the registered handshake outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cmd_pend_q  <= 1'b0;
            cmd_q       <= 8'h00;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_byte_q  <= 8'h00;
            timer_q     <= '0;
        end else begin
            state_q     <= state_d;
            cmd_pend_q  <= cmd_pend_d;
            cmd_q       <= cmd_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_byte_q  <= rsp_byte_d;
            timer_q     <= timer_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_byte  = rsp_byte_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_mac_kbd_bridge.sv
// Self-checking bench for mac_kbd_bridge: vector table, hand sequences and randomized traffic vs a queue model.
module tb_mac_kbd_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] ps2_key;
    logic        cmd_valid;
    logic [7:0]  cmd_byte;
    logic        cmd_ready;
    logic        rsp_valid;
    logic [7:0]  rsp_byte;
    logic        rsp_ready;
    logic        overflow;

    always #5 clk = ~clk;

    mac_kbd_bridge #(.c_mhz(100000), .c_fifo_depth(8), .c_inquiry_ms(1)) dut (
        .clk(clk), .reset(reset), .ps2_key(ps2_key),
        .cmd_valid(cmd_valid), .cmd_byte(cmd_byte), .cmd_ready(cmd_ready),
        .rsp_valid(rsp_valid), .rsp_byte(rsp_byte), .rsp_ready(rsp_ready),
        .overflow(overflow)
    );

    typedef struct { logic ext; logic [7:0] code; int raw; } key_t;
    typedef struct { logic [7:0] cmd; logic [7:0] rsp; } vec_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  model_q[$];
    bit          model_ovf = 1'b0;
    key_t        keys[16];
    vec_t        vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Toggle the event bit with new key data; the model records what the bridge must queue.
    task automatic drive_key(input int k, input bit pressed);
        int b;
        ps2_key = {~ps2_key[10], pressed, keys[k].ext, keys[k].code};
        if (keys[k].raw >= 0) begin
            b = (pressed ? 0 : 128) + (keys[k].raw % 64) * 2 + 1;
            if (model_q.size() < 8) model_q.push_back(8'(b));
            else model_ovf = 1'b1;
        end
    endtask

    task automatic key_event(input int k, input bit pressed);
        drive_key(k, pressed);
        tick();
    endtask

    function automatic logic [7:0] model_rsp(input logic [7:0] c);
        if (c == 8'h10 || c == 8'h14) begin
            if (model_q.size() > 0) return model_q.pop_front();
            return 8'h7B;
        end
        if (c == 8'h16) return 8'h0B;
        if (c == 8'h36) return 8'h7D;
        return 8'h77;
    endfunction

    // Send one command, optionally inject a key press at a given cycle, then optionally stall rsp_ready.
    task automatic run_cmd(input logic [7:0] c, input int key_at, input int key_idx, input int hold,
                           output logic [7:0] rb, output int lat);
        int  guard;
        bit  hold_ok;
        guard = 0;
        while (!cmd_ready && guard < 50) begin tick(); guard++; end
        if (!cmd_ready) check("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_byte  = c;
        tick();
        cmd_valid = 1'b0;
        cmd_byte  = 8'h00;
        lat = 1;
        while (!rsp_valid && lat < 400) begin
            if (lat == key_at) drive_key(key_idx, 1'b1);
            tick();
            lat++;
        end
        if (!rsp_valid) check("rsp_timeout", 32'(rsp_valid), 32'd1);
        rb = rsp_byte;
        if (hold > 0) begin
            hold_ok = 1'b1;
            for (int i = 0; i < hold; i++) begin
                tick();
                if (rsp_byte !== rb || cmd_ready !== 1'b0 || rsp_valid !== 1'b1) hold_ok = 1'b0;
            end
            check("hold_stable", 32'(hold_ok), 32'd1);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("rsp_valid_drop", 32'(rsp_valid), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        model_q.delete();
        model_ovf = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        logic [7:0] rb;
        logic [7:0] c;
        int         lat;
        int         n;
        int         k;

        keys[0]  = '{1'b0, 8'h1C, 8'h00};  keys[1]  = '{1'b0, 8'h1B, 8'h01};
        keys[2]  = '{1'b0, 8'h23, 8'h02};  keys[3]  = '{1'b0, 8'h2B, 8'h03};
        keys[4]  = '{1'b0, 8'h33, 8'h04};  keys[5]  = '{1'b0, 8'h34, 8'h05};
        keys[6]  = '{1'b0, 8'h1A, 8'h06};  keys[7]  = '{1'b0, 8'h22, 8'h07};
        keys[8]  = '{1'b0, 8'h21, 8'h08};  keys[9]  = '{1'b0, 8'h2A, 8'h09};
        keys[10] = '{1'b0, 8'h15, 8'h0C};  keys[11] = '{1'b0, 8'h29, 8'h31};
        keys[12] = '{1'b1, 8'h5A, 8'h34};  keys[13] = '{1'b0, 8'h00, -1};
        keys[14] = '{1'b1, 8'h1C, -1};     keys[15] = '{1'b0, 8'hFF, -1};

        vecs[0] = '{8'h14, 8'h7B}; vecs[1] = '{8'h16, 8'h0B};
        vecs[2] = '{8'h36, 8'h7D}; vecs[3] = '{8'h55, 8'h77};
        vecs[4] = '{8'h00, 8'h77}; vecs[5] = '{8'hFF, 8'h77};
        vecs[6] = '{8'h15, 8'h77}; vecs[7] = '{8'h17, 8'h77};

        reset = 1'b1; ps2_key = 11'h400; cmd_valid = 1'b0; cmd_byte = 8'h00; rsp_ready = 1'b0;
        tick(); tick(); tick();
        check("reset_cmd_ready", 32'(cmd_ready), 32'd0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_byte", 32'(rsp_byte), 32'h00);
        check("reset_overflow", 32'(overflow), 32'd0);
        reset = 1'b0;
        tick(); tick();
        check("idle_cmd_ready", 32'(cmd_ready), 32'd1);

        // Toggle level held through reset must not queue anything.
        run_cmd(8'h14, -1, 0, 0, rb, lat);
        check("no_push_after_reset", 32'(rb), 32'h7B);
        void'(model_rsp(8'h14));

        key_event(0, 1'b1);
        run_cmd(8'h14, -1, 0, 0, rb, lat);
        check("instant_a_down", 32'(rb), 32'h01);
        check("instant_latency", 32'(lat), 32'd2);
        void'(model_rsp(8'h14));

        key_event(0, 1'b1);
        key_event(0, 1'b0);
        run_cmd(8'h14, -1, 0, 0, rb, lat);
        check("press_byte", 32'(rb), 32'h01);
        run_cmd(8'h14, -1, 0, 0, rb, lat);
        check("release_byte", 32'(rb), 32'h81);
        run_cmd(8'h14, -1, 0, 0, rb, lat);
        check("drained_null", 32'(rb), 32'h7B);
        model_q.delete();

        for (int i = 0; i < 8; i++) begin
            run_cmd(vecs[i].cmd, -1, 0, 0, rb, lat);
            check($sformatf("vec%0d_rsp", i), 32'(rb), 32'(vecs[i].rsp));
            check($sformatf("vec%0d_lat", i), 32'(lat), 32'd2);
        end

        run_cmd(8'h10, -1, 0, 0, rb, lat);
        check("inquiry_timeout_rsp", 32'(rb), 32'h7B);
        check("inquiry_timeout_lat", 32'(lat), 32'd102);

        run_cmd(8'h10, 50, 1, 0, rb, lat);
        check("inquiry_key_rsp", 32'(rb), 32'h03);
        check("inquiry_key_by_53", 32'(lat <= 53), 32'd1);
        void'(model_rsp(8'h10));

        run_cmd(8'h16, -1, 0, 10, rb, lat);
        check("model_held", 32'(rb), 32'h0B);

        for (int it = 0; it < 40; it++) begin
            n = $urandom_range(0, 3);
            for (int j = 0; j < n; j++) begin
                if (model_q.size() < 7) begin
                    k = $urandom_range(0, 15);
                    key_event(k, 1'($urandom_range(0, 1)));
                end
            end
            case ($urandom_range(0, 5))
                0: c = 8'h10;
                1: c = 8'h14;
                2: c = 8'h16;
                3: c = 8'h36;
                4: c = 8'($urandom_range(0, 255));
                default: c = 8'h14;
            endcase
            run_cmd(c, -1, 0, 0, rb, lat);
            check($sformatf("rand%0d_cmd%0h", it, c), 32'(rb), 32'(model_rsp(c)));
        end
        check("rand_no_overflow", 32'(overflow), 32'(model_ovf));

        do_reset();
        for (int i = 0; i < 9; i++) key_event(i, 1'b1);
        check("overflow_set", 32'(overflow), 32'd1);
        check("overflow_model", 32'(model_ovf), 32'd1);
        for (int i = 0; i < 9; i++) begin
            run_cmd(8'h14, -1, 0, 0, rb, lat);
            check($sformatf("ovf_pop%0d", i), 32'(rb), 32'(model_rsp(8'h14)));
        end
        check("ovf_ninth_null", 32'(rb), 32'h7B);

        // Reset while a reply is pending and keys are queued, with overflow still sticky.
        while (!cmd_ready) tick();
        cmd_valid = 1'b1; cmd_byte = 8'h10;
        tick();
        cmd_valid = 1'b0;
        repeat (6) tick();
        for (int i = 0; i < 3; i++) key_event(i + 3, 1'b1);
        reset = 1'b1;
        tick();
        check("midreset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("midreset_overflow", 32'(overflow), 32'd0);
        reset = 1'b0;
        model_q.delete();
        model_ovf = 1'b0;
        tick(); tick();
        run_cmd(8'h14, -1, 0, 0, rb, lat);
        check("midreset_flushed", 32'(rb), 32'h7B);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
